demo_scene_sequencer: RTL and testbench
=======================================

DEMO_SCENE_SEQUENCER -- requirements
Module: demo_scene_sequencer

Interface
REQ-001 Parameter FRAMES_PER_BEAT, default 16: frames per beat; SHALL be a power of two, 2..16.
REQ-002 Parameter BEATS_PER_PART, default 8: beats per scene part; SHALL be a power of two.
REQ-003 Parameter FADE_FRAMES, default 4: frame ticks per skip fade step sequence; range 1..4.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 frame_tick  input  1  one-cycle pulse at pixel (0,0) of each frame.
REQ-007 skip  input  1  one-cycle request to jump to the next part.
REQ-008 pause  input  1  level; freezes the timeline while high.
REQ-009 part  output  3  current scene part 0..7.
REQ-010 frame_in_part  output  log2(FRAMES_PER_BEAT*BEATS_PER_PART)  frame index inside the part.
REQ-011 beat  output  log2(BEATS_PER_PART)  beat index inside the part.
REQ-012 envelope  output  5  beat decay, consumed by the effect datapath.
REQ-013 fade  output  2  brightness right-shift for the RGB path; 0 = full brightness.
REQ-014 title_en  output  1  title overlay enable.
REQ-015 loop_pulse  output  1  one-cycle pulse when part wraps from 7 to 0.

Function
REQ-016 State machine SHALL have states PLAY, PAUSED and SKIP_FADE; reset state is PLAY.
REQ-017 In PLAY, each frame_tick SHALL increment the frame counter {part, frame_in_part}; outputs change one cycle after the tick.
REQ-018 beat SHALL equal frame_in_part / FRAMES_PER_BEAT, and phase SHALL equal frame_in_part mod FRAMES_PER_BEAT.
REQ-019 envelope SHALL equal 31 - phase*(32/FRAMES_PER_BEAT), computed combinationally from registered state. It never underflows.
REQ-020 At frame_in_part maximum with a tick, frame_in_part SHALL wrap to 0 and part SHALL increment. From part 7 it wraps to 0, and loop_pulse is asserted for exactly one cycle.
REQ-021 Transition PLAY->PAUSED occurs when pause is high at a cycle. PAUSED->PLAY occurs when pause is low. In PAUSED, ticks are ignored and all outputs hold.
REQ-022 skip in PLAY or PAUSED SHALL enter SKIP_FADE with fade=0. Each subsequent frame_tick increments fade, and frame_in_part does not advance.
REQ-023 SKIP_FADE counts FADE_FRAMES ticks. It then sets part=part+1, wrapping 7->0 with loop_pulse. It also sets frame_in_part=0 and fade=0, and returns to PLAY. fade SHALL saturate at 3.
REQ-024 skip or pause while in SKIP_FADE SHALL be ignored. Pause is sampled again after return to PLAY.
REQ-025 skip and frame_tick in the same PLAY cycle: skip wins. The tick does not advance the timeline.
REQ-026 pause and skip in the same cycle: skip wins (enter SKIP_FADE).
REQ-027 fade SHALL be 0 in PLAY and PAUSED.
REQ-028 title_en SHALL be 1 when part==0. It SHALL also be 1 when part==7 and frame_in_part >= 3/4 of part length. Otherwise it is 0.

Reset
REQ-029 reset SHALL take priority over all inputs in the same cycle.
REQ-030 On reset, the following SHALL be 0 on the next edge: part, frame_in_part, beat, fade, title_en outputs follow (title_en=1 since part=0), loop_pulse=0, envelope=31, state=PLAY.
REQ-031 Reset asserted during SKIP_FADE or PAUSED SHALL abort it with no part increment.

Structure
REQ-032 The shared package SHALL hold the state enum (PLAY, PAUSED, SKIP_FADE), part encodings (PART_TITLE=0 .. PART_TITLE_TUNNEL=7) and default timing constants.
REQ-033 One sub-module, beat_envelope_gen, SHALL derive beat/phase/envelope from frame_in_part. All other logic stays in one module.
REQ-034 All outputs except envelope and title_en SHALL be registered. Those two are combinational from registers only.

Verification
REQ-035 The bench SHALL cover the following scenarios:
- Reset, then 16 ticks -> beat=1, envelope=31, frame_in_part=16, part=0.
- 1024 ticks from reset -> part back to 0, loop_pulse exactly once, coinciding with the 1024th tick update.
- pause high for 50 ticks at frame 10, then low, then 1 tick -> frame_in_part=11.
- skip at part 2, frame 40, then 4 ticks -> fade 1,2,3,3, then part=3, frame_in_part=0, fade=0, state PLAY.
- skip and frame_tick in the same cycle at frame 5 -> SKIP_FADE entered, frame_in_part stays 5.
- reset during SKIP_FADE with fade=2 -> part=0, fade=0, PLAY; then 96 ticks at part 7 via 7 skips -> title_en rises at frame_in_part=96.

Source files
------------

// File: rtl/demo_scene_sequencer_pkg.sv
// Shared types and default timing for the demo scene sequencer.
package demo_scene_sequencer_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        PAUSED    = 2'd1,
        SKIP_FADE = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        PART_TITLE        = 3'd0,
        PART_PLASMA       = 3'd1,
        PART_STARFIELD    = 3'd2,
        PART_ROTOZOOM     = 3'd3,
        PART_SCROLLER     = 3'd4,
        PART_BOBS         = 3'd5,
        PART_COPPER       = 3'd6,
        PART_TITLE_TUNNEL = 3'd7
    } part_t;

    localparam int DEF_FRAMES_PER_BEAT = 16;
    localparam int DEF_BEATS_PER_PART  = 8;
    localparam int DEF_FADE_FRAMES     = 4;

    localparam logic [1:0] FADE_MAX = 2'd3;

    // Brightness shift grows by one per fade tick and sticks at the darkest level.
    function automatic logic [1:0] fade_step(input logic [1:0] f);
        return (f == FADE_MAX) ? FADE_MAX : f + 2'd1;
    endfunction

endpackage

// File: rtl/demo_scene_sequencer_beat_envelope_gen.sv
// Splits the frame index into beat and phase and derives the per-beat decay envelope.
module beat_envelope_gen
    import demo_scene_sequencer_pkg::*;
#(
    parameter int  FRAMES_PER_BEAT = DEF_FRAMES_PER_BEAT,
    parameter int  BEATS_PER_PART  = DEF_BEATS_PER_PART,
    localparam int FIP_W           = $clog2(FRAMES_PER_BEAT * BEATS_PER_PART),
    localparam int BEAT_W          = $clog2(BEATS_PER_PART),
    localparam int PH_W            = $clog2(FRAMES_PER_BEAT)
) (
    input  logic [FIP_W-1:0]  i_frame_in_part,
    output logic [BEAT_W-1:0] o_beat,
    output logic [4:0]        o_envelope
);

    localparam int ENV_STEP = 32 / FRAMES_PER_BEAT;

    logic [PH_W-1:0] w_phase;
    logic [4:0]      w_drop;

    assign w_phase    = i_frame_in_part[PH_W-1:0];
    assign o_beat     = i_frame_in_part[FIP_W-1:PH_W];
    // Largest phase gives 31 - (FPB-1)*(32/FPB) >= 1, so the subtraction cannot wrap.
    assign w_drop     = 5'(int'(w_phase) * ENV_STEP);
    assign o_envelope = 5'd31 - w_drop;

endmodule

// File: rtl/demo_scene_sequencer.sv
// Demo timeline: frame/part counting, pause, skip-with-fade and title overlay control.
module demo_scene_sequencer
    import demo_scene_sequencer_pkg::*;
#(
    parameter int  FRAMES_PER_BEAT = DEF_FRAMES_PER_BEAT,
    parameter int  BEATS_PER_PART  = DEF_BEATS_PER_PART,
    parameter int  FADE_FRAMES     = DEF_FADE_FRAMES,
    localparam int FIP_W           = $clog2(FRAMES_PER_BEAT * BEATS_PER_PART),
    localparam int BEAT_W          = $clog2(BEATS_PER_PART)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_tick,
    input  logic              skip,
    input  logic              pause,
    output logic [2:0]        part,
    output logic [FIP_W-1:0]  frame_in_part,
    output logic [BEAT_W-1:0] beat,
    output logic [4:0]        envelope,
    output logic [1:0]        fade,
    output logic              title_en,
    output logic              loop_pulse
);

    localparam int               PART_LEN    = FRAMES_PER_BEAT * BEATS_PER_PART;
    localparam int               POS_W       = 3 + FIP_W;
    localparam logic [FIP_W-1:0] TITLE_START = FIP_W'((PART_LEN * 3) / 4);

    seq_state_t       r_state, w_state_nxt;
    logic [2:0]       r_part, w_part_nxt;
    logic [FIP_W-1:0] r_fip, w_fip_nxt;
    logic [1:0]       r_fade, w_fade_nxt;
    logic [2:0]       r_fade_cnt, w_fade_cnt_nxt;
    logic             r_loop, w_loop_nxt;
    logic [POS_W-1:0] w_pos_inc;
    logic             w_pos_last;

    assign w_pos_inc  = {r_part, r_fip} + POS_W'(1);
    assign w_pos_last = &{r_part, r_fip};

    always_comb begin
        w_state_nxt    = r_state;
        w_part_nxt     = r_part;
        w_fip_nxt      = r_fip;
        w_fade_nxt     = r_fade;
        w_fade_cnt_nxt = r_fade_cnt;
        w_loop_nxt     = 1'b0;
        unique case (r_state)
            PLAY: begin
                if (skip) begin
                    w_state_nxt    = SKIP_FADE;
                    w_fade_nxt     = 2'd0;
                    w_fade_cnt_nxt = 3'd0;
                end else if (pause) begin
                    w_state_nxt = PAUSED;
                end else if (frame_tick) begin
                    {w_part_nxt, w_fip_nxt} = w_pos_inc;
                    w_loop_nxt              = w_pos_last;
                end
            end
            PAUSED: begin
                if (skip) begin
                    w_state_nxt    = SKIP_FADE;
                    w_fade_nxt     = 2'd0;
                    w_fade_cnt_nxt = 3'd0;
                end else if (!pause) begin
                    w_state_nxt = PLAY;
                end
            end
            SKIP_FADE: begin
                // The last fade level is shown for one cycle before the jump lands.
                if (r_fade_cnt == 3'(FADE_FRAMES)) begin
                    w_state_nxt    = PLAY;
                    w_part_nxt     = r_part + 3'd1;
                    w_fip_nxt      = '0;
                    w_fade_nxt     = 2'd0;
                    w_fade_cnt_nxt = 3'd0;
                    w_loop_nxt     = (r_part == PART_TITLE_TUNNEL);
                end else if (frame_tick) begin
                    w_fade_cnt_nxt = r_fade_cnt + 3'd1;
                    w_fade_nxt     = fade_step(r_fade);
                end
            end
            default: w_state_nxt = PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PLAY;
            r_part     <= 3'd0;
            r_fip      <= '0;
            r_fade     <= 2'd0;
            r_fade_cnt <= 3'd0;
            r_loop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_part     <= w_part_nxt;
            r_fip      <= w_fip_nxt;
            r_fade     <= w_fade_nxt;
            r_fade_cnt <= w_fade_cnt_nxt;
            r_loop     <= w_loop_nxt;
        end
    end

    beat_envelope_gen #(
        .FRAMES_PER_BEAT (FRAMES_PER_BEAT),
        .BEATS_PER_PART  (BEATS_PER_PART)
    ) u_beat_env (
        .i_frame_in_part (r_fip),
        .o_beat          (beat),
        .o_envelope      (envelope)
    );

    assign part          = r_part;
    assign frame_in_part = r_fip;
    assign fade          = r_fade;
    assign loop_pulse    = r_loop;
    assign title_en      = (r_part == PART_TITLE) ||
                           ((r_part == PART_TITLE_TUNNEL) && (r_fip >= TITLE_START));

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Directed bench for demo_scene_sequencer with a behavioural timeline model checked every cycle.
module tb_demo_scene_sequencer;

    localparam int FPB      = 16;
    localparam int BPP      = 8;
    localparam int FADE_N   = 4;
    localparam int PART_LEN = FPB * BPP;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       skip = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] part;
    logic [6:0] frame_in_part;
    logic [2:0] beat;
    logic [4:0] envelope;
    logic [1:0] fade;
    logic       title_en;
    logic       loop_pulse;

    demo_scene_sequencer #(
        .FRAMES_PER_BEAT (FPB),
        .BEATS_PER_PART  (BPP),
        .FADE_FRAMES     (FADE_N)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .skip          (skip),
        .pause         (pause),
        .part          (part),
        .frame_in_part (frame_in_part),
        .beat          (beat),
        .envelope      (envelope),
        .fade          (fade),
        .title_en      (title_en),
        .loop_pulse    (loop_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int loops_seen = 0;

    // Model: mode 0 = playing, 1 = paused, 2 = fading out towards the next part.
    int m_part, m_fip, m_mode, m_fade, m_fticks;
    int m_loop;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit t, input bit s, input bit p, input bit r);
        m_loop = 0;
        if (r) begin
            m_part = 0; m_fip = 0; m_mode = 0; m_fade = 0; m_fticks = 0;
        end else if (m_mode == 2) begin
            if (m_fticks == FADE_N) begin
                if (m_part == 7) m_loop = 1;
                m_part = (m_part + 1) % 8;
                m_fip = 0; m_fade = 0; m_fticks = 0; m_mode = 0;
            end else if (t) begin
                m_fticks++;
                m_fade = (m_fade + 1 > 3) ? 3 : m_fade + 1;
            end
        end else if (s) begin
            m_mode = 2; m_fade = 0; m_fticks = 0;
        end else if (m_mode == 1) begin
            if (!p) m_mode = 0;
        end else if (p) begin
            m_mode = 1;
        end else if (t) begin
            m_fip++;
            if (m_fip == PART_LEN) begin
                m_fip = 0;
                if (m_part == 7) m_loop = 1;
                m_part = (m_part + 1) % 8;
            end
        end
    endtask

    task automatic compare_model();
        chk("part", part, m_part);
        chk("frame_in_part", frame_in_part, m_fip);
        chk("beat", beat, m_fip / FPB);
        chk("envelope", envelope, 31 - (m_fip % FPB) * (32 / FPB));
        chk("fade", fade, m_fade);
        chk("title_en", title_en, (m_part == 0 || (m_part == 7 && m_fip * 4 >= PART_LEN * 3)) ? 1 : 0);
        chk("loop_pulse", loop_pulse, m_loop);
        if (loop_pulse === 1'b1) loops_seen++;
    endtask

    task automatic step(input bit t, input bit s, input bit p, input bit r);
        frame_tick = t; skip = s; pause = p; reset = r;
        @(posedge clk);
        model_step(t, s, p, r);
        @(negedge clk);
        compare_model();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_skip(input bit with_pause);
        step(1'b0, 1'b1, with_pause, 1'b0);
        for (int i = 0; i < FADE_N; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    int loops0;

    initial begin
        // Reset values and the first beat
        do_reset();
        chk("rst_part", part, 0);
        chk("rst_fip", frame_in_part, 0);
        chk("rst_beat", beat, 0);
        chk("rst_env", envelope, 31);
        chk("rst_fade", fade, 0);
        chk("rst_title", title_en, 1);
        chk("rst_loop", loop_pulse, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_fip", frame_in_part, 1);
        chk("t1_env", envelope, 29);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        tick_n(14);
        chk("t15_env", envelope, 1);
        chk("t15_beat", beat, 0);
        tick_n(1);
        chk("t16_fip", frame_in_part, 16);
        chk("t16_beat", beat, 1);
        chk("t16_env", envelope, 31);
        chk("t16_part", part, 0);

        // Full loop of 1024 ticks
        do_reset();
        loops0 = loops_seen;
        tick_n(1023);
        chk("l1023_part", part, 7);
        chk("l1023_fip", frame_in_part, 127);
        chk("l1023_title", title_en, 1);
        chk("l1023_loop", loop_pulse, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("l1024_loop", loop_pulse, 1);
        chk("l1024_part", part, 0);
        chk("l1024_fip", frame_in_part, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("l1024_loop_drop", loop_pulse, 0);
        chk("loop_count", loops_seen - loops0, 1);

        // Pause holds the timeline
        do_reset();
        tick_n(10);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("pause_fip", frame_in_part, 10);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("unpause_fip", frame_in_part, 11);

        // Skip with fade from part 2 frame 40
        do_reset();
        tick_n(2 * PART_LEN + 40);
        chk("pre_skip_part", part, 2);
        chk("pre_skip_fip", frame_in_part, 40);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("skip_fade0", fade, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skip_fade1", fade, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("skip_fade2", fade, 2);
        chk("skip_fip_hold", frame_in_part, 40);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skip_fade3", fade, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skip_fade3_sat", fade, 3);
        chk("skip_part_hold", part, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("skip_done_part", part, 3);
        chk("skip_done_fip", frame_in_part, 0);
        chk("skip_done_fade", fade, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skip_play_fip", frame_in_part, 1);

        // Skip and tick together at frame 5
        do_reset();
        tick_n(5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("skiptick_fip", frame_in_part, 5);
        chk("skiptick_fade", fade, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("skiptick_fade1", fade, 1);
        chk("skiptick_fip_hold", frame_in_part, 5);

        // Reset aborts a fade at level 2
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_fade2", fade, 2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("abort_part", part, 0);
        chk("abort_fade", fade, 0);
        chk("abort_fip", frame_in_part, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_play_fip", frame_in_part, 1);

        // Seven skips to the last part, first one with pause in the same cycle
        do_reset();
        do_skip(1'b1);
        chk("skip_pause_part", part, 1);
        for (int i = 0; i < 6; i++) do_skip(1'b0);
        chk("p7_part", part, 7);
        chk("p7_title_start", title_en, 0);
        tick_n(95);
        chk("p7_fip95", frame_in_part, 95);
        chk("p7_title95", title_en, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("p7_fip96", frame_in_part, 96);
        chk("p7_title96", title_en, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        loops0 = loops_seen;
        do_skip(1'b0);
        chk("p7_skip_part", part, 0);
        chk("p7_skip_loop_count", loops_seen - loops0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
